// File: rtl/tiny_riscv_prog_loader.sv
// tiny_riscv_prog_loader
// Host-side program loader for a tiny RISC-V style core. The host streams a
// length byte followed by N instruction bytes (and, when the checksum option
// is built in, a trailing checksum byte). The core fetches combinationally
// from the loaded image and is released via cpu_run once the image is valid.
// Unloaded words read as 0xFF, the HALT encoding.
//
// Optional feature: define LOADER_CHECKSUM_EN to build in the CHK state and
// the modulo-256 running-sum check. Without it, the last data byte goes
// straight to RUN and state encoding 3 is unused.

module tiny_riscv_prog_loader #(
  parameter int MEM_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       host_start,
  input  logic       host_valid,
  input  logic [7:0] host_data,
  output logic       host_ready,
  input  logic [3:0] fetch_addr,
  output logic [7:0] fetch_data,
  output logic       cpu_run,
  output logic       load_err,
  output logic [2:0] load_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    CHK  = 3'd3,
`endif
    RUN  = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam logic [7:0] HALT_WORD = 8'hFF;

  state_t     state;
  state_t     next_state;
  logic [7:0] mem [MEM_DEPTH];
  logic [3:0] ptr;
  logic [7:0] len_q;
  logic       xfer;
  logic       last_data;
  logic       len_bad;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] sum_final;
`endif

  // Handshake and decode helpers shared by the state logic and the datapath
  always_comb begin
    host_ready = (state == LEN) || (state == DATA)
`ifdef LOADER_CHECKSUM_EN
                 || (state == CHK)
`endif
                 ;
    xfer      = host_valid && host_ready;
    last_data = ({4'b0000, ptr} == (len_q - 8'd1));
    len_bad   = (host_data == 8'd0) || (host_data > 8'(MEM_DEPTH));
`ifdef LOADER_CHECKSUM_EN
    sum_final = sum + host_data;
`endif
  end

  // Status outputs are pure decodes of the current state
  always_comb begin
    cpu_run    = (state == RUN);
    load_err   = (state == ERR);
    load_state = state;
    fetch_data = mem[fetch_addr];
  end

  // State register; rst outranks everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; host_start restarts a load from any state and wins
  // over a simultaneous byte transfer
  always_comb begin
    next_state = state;
    if (host_start) begin
      next_state = LEN;
    end else begin
      case (state)
        LEN: begin
          if (xfer) begin
            next_state = len_bad ? ERR : DATA;
          end
        end
        DATA: begin
          if (xfer && last_data) begin
`ifdef LOADER_CHECKSUM_EN
            next_state = CHK;
`else
            next_state = RUN;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            next_state = (sum_final == 8'd0) ? RUN : ERR;
          end
        end
`endif
        default: next_state = state;
      endcase
    end
  end

  // Datapath: memory image, write pointer, captured length and running sum.
  // Reset and restart both wipe the image back to HALT words.
  always_ff @(posedge clk) begin
    if (rst || host_start) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= HALT_WORD;
      end
      ptr   <= 4'd0;
      len_q <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
      sum   <= 8'd0;
`endif
    end else if (xfer) begin
      case (state)
        LEN: begin
          len_q <= host_data;
`ifdef LOADER_CHECKSUM_EN
          sum   <= host_data;
`endif
        end
        DATA: begin
          mem[ptr] <= host_data;
          ptr      <= ptr + 4'd1;
`ifdef LOADER_CHECKSUM_EN
          sum      <= sum_final;
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_riscv_prog_loader.sv
// Directed testbench for tiny_riscv_prog_loader. Builds with or without
// LOADER_CHECKSUM_EN; the checksum-specific steps follow the same macro.

module tb_tiny_riscv_prog_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       host_start;
  logic       host_valid;
  logic [7:0] host_data;
  logic       host_ready;
  logic [3:0] fetch_addr;
  logic [7:0] fetch_data;
  logic       cpu_run;
  logic       load_err;
  logic [2:0] load_state;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  tiny_riscv_prog_loader #(.MEM_DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .host_start (host_start),
    .host_valid (host_valid),
    .host_data  (host_data),
    .host_ready (host_ready),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .cpu_run    (cpu_run),
    .load_err   (load_err),
    .load_state (load_state)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 ns past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One cycle with host_valid asserted carrying byte b
  task automatic applyStimulus(input logic [7:0] b);
    host_valid = 1'b1;
    host_data  = b;
    tick();
    host_valid = 1'b0;
  endtask

  task automatic pulse_start();
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
  endtask

  task automatic check_fetch(input string tag, input int addr, input logic [7:0] exp);
    fetch_addr = 4'(addr);
    #1;
    checkOutput(tag, {24'd0, fetch_data}, {24'd0, exp});
  endtask

  // Words from addr 'from' up to 15 must still read HALT
  task automatic check_ff_from(input string tag, input int from);
    for (int a = from; a < 16; a++) begin
      check_fetch(tag, a, 8'hFF);
    end
  endtask

  task automatic check_status(input string tag, input logic [2:0] st,
                              input logic rdy, input logic run, input logic err);
    checkOutput({tag, ".state"}, {29'd0, load_state}, {29'd0, st});
    checkOutput({tag, ".ready"}, {31'd0, host_ready}, {31'd0, rdy});
    checkOutput({tag, ".run"},   {31'd0, cpu_run},    {31'd0, run});
    checkOutput({tag, ".err"},   {31'd0, load_err},   {31'd0, err});
  endtask

  initial begin
    rst        = 1'b1;
    host_start = 1'b0;
    host_valid = 1'b0;
    host_data  = 8'h00;
    fetch_addr = 4'd0;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check_status("reset", S_IDLE, 1'b0, 1'b0, 1'b0);
    check_ff_from("reset_mem", 0);

    // host_valid in IDLE is ignored
    applyStimulus(8'h55);
    check_status("idle_valid", S_IDLE, 1'b0, 1'b0, 1'b0);
    check_fetch("idle_mem0", 0, 8'hFF);

    // Basic load of three words
    pulse_start();
    check_status("start", S_LEN, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h03);
    check_status("len3", S_DATA, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h88);
    check_fetch("w0_visible", 0, 8'h88);
    applyStimulus(8'h91);
    applyStimulus(8'hFF);
`ifdef LOADER_CHECKSUM_EN
    check_status("to_chk", S_CHK, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hE5);
`endif
    check_status("run", S_RUN, 1'b0, 1'b1, 1'b0);
    check_fetch("run_w0", 0, 8'h88);
    check_fetch("run_w1", 1, 8'h91);
    check_fetch("run_w2", 2, 8'hFF);
    check_ff_from("run_tail", 3);

    // host_valid in RUN is ignored
    applyStimulus(8'h12);
    check_status("run_valid", S_RUN, 1'b0, 1'b1, 1'b0);
    check_fetch("run_valid_w0", 0, 8'h88);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum ends in ERR
    pulse_start();
    applyStimulus(8'h03);
    applyStimulus(8'h88);
    applyStimulus(8'h91);
    applyStimulus(8'hFF);
    applyStimulus(8'h00);
    check_status("bad_chk", S_ERR, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'hE5);
    check_status("err_hold", S_ERR, 1'b0, 1'b0, 1'b1);
`endif

    // Length 0 rejected without writing memory
    pulse_start();
    check_status("restart_from_run", S_LEN, 1'b1, 1'b0, 1'b0);
    check_fetch("restart_wipe", 0, 8'hFF);
    applyStimulus(8'h00);
    check_status("len0", S_ERR, 1'b0, 1'b0, 1'b1);
    check_ff_from("len0_mem", 0);

    // Length 17 rejected
    pulse_start();
    applyStimulus(8'h11);
    check_status("len17", S_ERR, 1'b0, 1'b0, 1'b1);
    check_ff_from("len17_mem", 0);

    // Restart mid-DATA, with a simultaneous byte that must be dropped
    pulse_start();
    applyStimulus(8'h04);
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    check_fetch("pre_restart_w1", 1, 8'hBB);
    host_start = 1'b1;
    host_valid = 1'b1;
    host_data  = 8'h77;
    tick();
    host_start = 1'b0;
    host_valid = 1'b0;
    check_status("mid_restart", S_LEN, 1'b1, 1'b0, 1'b0);
    check_ff_from("mid_restart_mem", 0);
    applyStimulus(8'h04);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    applyStimulus(8'h04);
`ifdef LOADER_CHECKSUM_EN
    applyStimulus(8'hF2);
`endif
    check_status("reload", S_RUN, 1'b0, 1'b1, 1'b0);
    check_fetch("reload_w0", 0, 8'h01);
    check_fetch("reload_w3", 3, 8'h04);
    check_ff_from("reload_tail", 4);

    // host_valid toggling in DATA: only handshaked bytes land, in order
    pulse_start();
    applyStimulus(8'h03);
    host_data = 8'h99;
    tick();
    applyStimulus(8'h21);
    host_data = 8'h98;
    tick();
    applyStimulus(8'h22);
    host_data = 8'h97;
    tick();
    check_status("toggle_mid", S_DATA, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h23);
`ifdef LOADER_CHECKSUM_EN
    applyStimulus(8'h97);
`endif
    check_status("toggle_run", S_RUN, 1'b0, 1'b1, 1'b0);
    check_fetch("toggle_w0", 0, 8'h21);
    check_fetch("toggle_w1", 1, 8'h22);
    check_fetch("toggle_w2", 2, 8'h23);
    check_fetch("toggle_w3", 3, 8'hFF);

    // Full 16-word load
    pulse_start();
    applyStimulus(8'h10);
    for (int n = 0; n < 16; n++) begin
      applyStimulus(8'(n));
    end
`ifdef LOADER_CHECKSUM_EN
    check_status("full_chk", S_CHK, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h78);
`endif
    check_status("full_run", S_RUN, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 16; n++) begin
      check_fetch("full_word", n, 8'(n));
    end

    // rst during DATA wins over a transfer
    pulse_start();
    applyStimulus(8'h04);
    applyStimulus(8'hAB);
    rst        = 1'b1;
    host_valid = 1'b1;
    host_data  = 8'hCD;
    tick();
    rst        = 1'b0;
    host_valid = 1'b0;
    check_status("rst_mid", S_IDLE, 1'b0, 1'b0, 1'b0);
    check_ff_from("rst_mid_mem", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
